// File: rtl/clk_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : clk_phase_scheduler
// Description : Programmable processor-period sequencer on the base clock,
//               issuing fetch/data/commit enables with run/halt/step and stall.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_phase_scheduler #(
    parameter int DIV_W       = 4,
    parameter int DEFAULT_DIV = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic             step_req,
    input  logic [DIV_W-1:0] div_sel,
    input  logic             div_load,
    input  logic             stall_req,
    output logic             imem_en,
    output logic             dmem_en,
    output logic             proc_en,
    output logic             regfile_en,
    output logic [DIV_W-1:0] phase,
    output logic             busy,
    output logic             step_done,
    output logic [CNT_W-1:0] period_cnt
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_RUN     = 2'd1;
    localparam logic [1:0]       c_STEP    = 2'd2;
    localparam logic [DIV_W-1:0] c_ONE     = DIV_W'(1);
    localparam logic [DIV_W-1:0] c_TWO     = DIV_W'(2);
    localparam logic [DIV_W-1:0] c_DEF_DIV = DIV_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    logic [1:0]       r_state,    w_state_nxt;
    logic [DIV_W-1:0] r_phase,    w_phase_nxt;
    logic [DIV_W-1:0] r_div,      w_div_nxt;
    logic [DIV_W-1:0] r_pend,     w_pend_nxt;
    logic             r_pend_vld, w_pend_vld_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;

    logic w_active;
    logic w_last;
    logic w_commit;
    logic w_apply;

    assign w_active = (r_state != c_IDLE);
    assign w_last   = w_active && (r_phase == r_div - c_ONE);
    // The only path from an input to an output: stall gates the commit strobe.
    assign w_commit = w_last && !stall_req;
    assign w_apply  = r_pend_vld && (w_commit || (r_state == c_IDLE));

    assign imem_en    = w_active && (r_phase == '0);
    assign dmem_en    = w_active && (r_phase == r_div - c_TWO);
    assign proc_en    = w_commit;
    assign regfile_en = w_commit;
    assign phase      = r_phase;
    assign busy       = w_active;
    assign step_done  = w_commit && (r_state == c_STEP);
    assign period_cnt = r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= c_IDLE;
            r_phase    <= '0;
            r_div      <= c_DEF_DIV;
            r_pend     <= c_DEF_DIV;
            r_pend_vld <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_phase    <= w_phase_nxt;
            r_div      <= w_div_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_phase_nxt    = r_phase;
        w_div_nxt      = r_div;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_cnt_nxt      = r_cnt;

        if (w_apply) begin
            w_div_nxt      = r_pend;
            w_pend_vld_nxt = 1'b0;
        end
        // A load in the same cycle as an apply stays pending for the next boundary.
        if (div_load) begin
            w_pend_nxt     = (div_sel < c_TWO) ? c_TWO : div_sel;
            w_pend_vld_nxt = 1'b1;
        end

        case (r_state)
            c_IDLE: begin
                w_phase_nxt = '0;
                if (run) begin
                    w_state_nxt = c_RUN;
                end else if (step_req) begin
                    w_state_nxt = c_STEP;
                end
            end
            c_RUN, c_STEP: begin
                if (w_commit) begin
                    w_cnt_nxt   = r_cnt + c_CNT_ONE;
                    w_phase_nxt = '0;
                    if ((r_state == c_STEP) || !run) begin
                        w_state_nxt = c_IDLE;
                    end
                end else if (!w_last) begin
                    w_phase_nxt = r_phase + c_ONE;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
